// File: rtl/ryuki_datatypes.sv
// Shared trace datatypes for the trace scheduler.
// Optional feature macro: TRACE_SCHEDULER_TIMESTAMP_EN adds the timestamp field to FIFO entries.
package ryuki_datatypes;

    // Trace record emitted by a producer.
    typedef logic [31:0] trace_output;

    localparam int unsigned TRACE_SRC_IDX_WIDTH    = 3;   // covers up to 8 sources
    localparam int unsigned TRACE_DROP_COUNT_WIDTH = 16;
    localparam int unsigned TRACE_TIMESTAMP_WIDTH  = 32;

    // One buffered record on its way to the sink.
    typedef struct packed {
        trace_output                      data;
        logic [TRACE_SRC_IDX_WIDTH-1:0]   source;
`ifdef TRACE_SCHEDULER_TIMESTAMP_EN
        logic [TRACE_TIMESTAMP_WIDTH-1:0] timestamp;
`endif
    } trace_sched_entry;

endpackage

// File: rtl/trace_fifo.sv
// Output FIFO for the trace scheduler: power-of-two depth, generic entry type.
// Head reads as all-zero while empty so no stale entry is ever presented.
module trace_fifo #(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = logic
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // Present the head entry, masked to zero when empty.
    always_comb begin
        head = mem[rd_ptr];
        if (empty) begin
            head = '0;
        end
    end

    // Storage write; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/trace_scheduler.sv
// Trace scheduler: per-source holding registers, round-robin arbiter, output FIFO and
// saturating drop counter. Optional macro TRACE_SCHEDULER_TIMESTAMP_EN enables capture
// timestamps; without it out_timestamp is tied to zero and no timestamp state exists.
module trace_scheduler
    import ryuki_datatypes::*;
#(
    parameter int unsigned NUM_SOURCES = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_SOURCES-1:0]                src_valid,
    input  trace_output [NUM_SOURCES-1:0]         src_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output trace_output                           out_data,
    output logic [$clog2(NUM_SOURCES)-1:0]        out_source,
    output logic [TRACE_TIMESTAMP_WIDTH-1:0]      out_timestamp,
    input  logic                                  drop_clr,
    output logic [TRACE_DROP_COUNT_WIDTH-1:0]     drop_count,
    output logic                                  drop_sticky
);
    localparam int unsigned SRC_W = $clog2(NUM_SOURCES);
    localparam int unsigned DW    = TRACE_DROP_COUNT_WIDTH;

    logic [NUM_SOURCES-1:0] hold_full;
    trace_output            hold_data [NUM_SOURCES];
`ifdef TRACE_SCHEDULER_TIMESTAMP_EN
    logic [TRACE_TIMESTAMP_WIDTH-1:0] ts_count;
    logic [TRACE_TIMESTAMP_WIDTH-1:0] hold_ts [NUM_SOURCES];
`endif

    logic [SRC_W-1:0]       prio;
    logic                   grant_valid;
    logic [SRC_W-1:0]       grant_idx;
    logic [NUM_SOURCES-1:0] grant_vec;
    logic [NUM_SOURCES-1:0] drop;
    logic [3:0]             drop_num;
    logic [DW-1:0]          drop_base;
    logic [DW:0]            drop_sum;
    logic [DW-1:0]          drop_next;

    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    trace_sched_entry push_entry;
    trace_sched_entry head;
    logic             unused_src_bits;

    assign pop = out_valid && out_ready;

    // Round-robin pick: walk offsets downwards so the smallest offset from prio wins.
    always_comb begin
        int unsigned idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        if (!fifo_full || pop) begin
            for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
                idx = 32'(prio) + 32'(k);
                if (idx >= NUM_SOURCES) begin
                    idx = idx - NUM_SOURCES;
                end
                if (hold_full[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SRC_W'(idx);
                end
            end
        end
        grant_vec = '0;
        if (grant_valid) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    // Drops: a full holding register that is not being drained this cycle rejects new data.
    always_comb begin
        drop     = src_valid & hold_full & ~grant_vec;
        drop_num = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            drop_num = drop_num + 4'(drop[i]);
        end
        drop_base = drop_clr ? '0 : drop_count;
        drop_sum  = {1'b0, drop_base} + (DW + 1)'(drop_num);
        drop_next = drop_sum[DW] ? '1 : drop_sum[DW-1:0];
    end

    // Build the FIFO entry for the granted source.
    always_comb begin
        push_entry        = '0;
        push_entry.data   = hold_data[grant_idx];
        push_entry.source = TRACE_SRC_IDX_WIDTH'(grant_idx);
`ifdef TRACE_SCHEDULER_TIMESTAMP_EN
        push_entry.timestamp = hold_ts[grant_idx];
`endif
    end

    // Holding registers, priority pointer and drop bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_full   <= '0;
            prio        <= '0;
            drop_count  <= '0;
            drop_sticky <= 1'b0;
            for (int i = 0; i < NUM_SOURCES; i++) begin
                hold_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SOURCES; i++) begin
                // A register drained this cycle can take the new record at the same edge.
                if (src_valid[i] && (!hold_full[i] || grant_vec[i])) begin
                    hold_full[i] <= 1'b1;
                    hold_data[i] <= src_data[i];
                end else if (grant_vec[i]) begin
                    hold_full[i] <= 1'b0;
                end
            end
            if (grant_valid) begin
                prio <= (32'(grant_idx) == NUM_SOURCES - 1) ? '0 : grant_idx + SRC_W'(1);
            end
            drop_count  <= drop_next;
            drop_sticky <= (drop_sticky && !drop_clr) || (|drop);
        end
    end

`ifdef TRACE_SCHEDULER_TIMESTAMP_EN
    // Free-running cycle counter and per-source capture timestamps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_count <= '0;
            for (int i = 0; i < NUM_SOURCES; i++) begin
                hold_ts[i] <= '0;
            end
        end else begin
            ts_count <= ts_count + 32'd1;
            for (int i = 0; i < NUM_SOURCES; i++) begin
                if (src_valid[i] && (!hold_full[i] || grant_vec[i])) begin
                    hold_ts[i] <= ts_count;
                end
            end
        end
    end
    assign out_timestamp = head.timestamp;
`else
    assign out_timestamp = '0;
`endif

    trace_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (trace_sched_entry)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant_valid),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid       = !fifo_empty;
    assign out_data        = head.data;
    assign out_source      = head.source[SRC_W-1:0];
    assign unused_src_bits = ^head.source;

endmodule

// File: tb/tb_trace_scheduler.sv
// Testbench for trace_scheduler: constant vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_trace_scheduler;
    import ryuki_datatypes::*;

    localparam int unsigned NS = 2;
    localparam int unsigned FD = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     src_valid;
    trace_output [NS-1:0] src_data;
    logic              out_valid;
    logic              out_ready;
    trace_output       out_data;
    logic [0:0]        out_source;
    logic [31:0]       out_timestamp;
    logic              drop_clr;
    logic [15:0]       drop_count;
    logic              drop_sticky;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trace_scheduler #(
        .NUM_SOURCES (NS),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .src_valid     (src_valid),
        .src_data      (src_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_source    (out_source),
        .out_timestamp (out_timestamp),
        .drop_clr      (drop_clr),
        .drop_count    (drop_count),
        .drop_sticky   (drop_sticky)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] data;
        int          src;
        logic [31:0] ts;
    } rec_t;

    rec_t        m_q[$];
    bit          m_full [NS];
    logic [31:0] m_hdata [NS];
    logic [31:0] m_hts [NS];
    int          m_p;
    int          m_dc;
    bit          m_sticky;
    logic [31:0] m_time;

    function automatic void model_reset();
        m_q.delete();
        for (int i = 0; i < NS; i++) begin
            m_full[i] = 0;
            m_hdata[i] = '0;
            m_hts[i] = '0;
        end
        m_p = 0;
        m_dc = 0;
        m_sticky = 0;
        m_time = '0;
    endfunction

    // One clock of the scheduler, expressed as sequential rules on the model state.
    function automatic void model_step(logic [1:0] sv, logic [31:0] d0, logic [31:0] d1,
                                       logic rdy, logic clr);
        bit   do_pop;
        bit   room;
        int   g;
        int   drops;
        rec_t r;
        logic [31:0] din [NS];
        din[0] = d0;
        din[1] = d1;
        do_pop = (m_q.size() > 0) && rdy;
        room   = (m_q.size() < FD) || do_pop;
        g = -1;
        if (room) begin
            for (int k = 0; k < NS; k++) begin
                if (g < 0 && m_full[(m_p + k) % NS]) g = (m_p + k) % NS;
            end
        end
        if (do_pop) void'(m_q.pop_front());
        if (g >= 0) begin
            r.data = m_hdata[g];
            r.src  = g;
            r.ts   = m_hts[g];
            m_q.push_back(r);
            m_full[g] = 0;
            m_p = (g + 1) % NS;
        end
        drops = 0;
        for (int i = 0; i < NS; i++) begin
            if (sv[i]) begin
                if (m_full[i]) drops++;
                else begin
                    m_full[i] = 1;
                    m_hdata[i] = din[i];
                    m_hts[i] = m_time;
                end
            end
        end
        if (clr) begin
            m_dc = 0;
            m_sticky = 0;
        end
        m_dc = (m_dc + drops > 65535) ? 65535 : m_dc + drops;
        if (drops > 0) m_sticky = 1;
        m_time = m_time + 32'd1;
    endfunction

    function automatic logic [82:0] model_out();
        logic        v = 1'b0;
        logic [31:0] d = '0;
        logic [0:0]  s = '0;
        logic [31:0] ts = '0;
        if (m_q.size() > 0) begin
            v = 1'b1;
            d = m_q[0].data;
            s = 1'(m_q[0].src);
`ifdef TRACE_SCHEDULER_TIMESTAMP_EN
            ts = m_q[0].ts;
`endif
        end
        return {v, d, s, ts, 16'(m_dc), m_sticky};
    endfunction

    function automatic logic [82:0] observed();
        return {out_valid, out_data, out_source, out_timestamp, drop_count, drop_sticky};
    endfunction

    task automatic check(input string name, input logic [82:0] got, input logic [82:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h required=%h", name, got, exp);
        end
    endtask

    // Drive one cycle, advance the model at the edge, and compare just after it.
    task automatic cycle(input logic [1:0] sv, input logic [31:0] d0, input logic [31:0] d1,
                         input logic rdy, input logic clr, input bit cmp);
        src_valid = sv;
        src_data[0] = d0;
        src_data[1] = d1;
        out_ready = rdy;
        drop_clr = clr;
        @(posedge clk);
        model_step(sv, d0, d1, rdy, clr);
        #1;
        if (cmp) check("model", observed(), model_out());
    endtask

    task automatic do_reset();
        rst = 1'b0;
        src_valid = '0;
        src_data = '0;
        out_ready = 1'b0;
        drop_clr = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset_state", observed(), '0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  sv;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [31:0] edata;
        logic [0:0]  esrc;
        logic [31:0] ets;
        logic [15:0] edc;
        logic        est;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    function automatic void row(int i, logic [1:0] sv, logic [31:0] d0, logic [31:0] d1,
                                logic clr, logic ev, logic [31:0] ed, logic es,
                                logic [31:0] ets, logic [15:0] edc, logic est);
        tbl[i].sv = sv;
        tbl[i].d0 = d0;
        tbl[i].d1 = d1;
        tbl[i].rdy = 1'b1;
        tbl[i].clr = clr;
        tbl[i].ev = ev;
        tbl[i].edata = ed;
        tbl[i].esrc = es;
        tbl[i].ets = ets;
        tbl[i].edc = edc;
        tbl[i].est = est;
    endfunction

    initial begin
        logic [31:0] ets;
        logic [1:0]  rsv;
        logic        rrdy;
        logic        rclr;

        // Row index equals the cycle number after reset release.
        for (int i = 0; i < 5; i++) row(i, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        row(5,  2'b01, 32'hCAFE_0005, 0, 0, 0, 0, 0, 0, 0, 0);
        row(6,  2'b00, 0, 0, 0, 1, 32'hCAFE_0005, 0, 5, 0, 0);
        row(7,  2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        row(8,  2'b10, 0, 32'hBEEF_0008, 0, 0, 0, 0, 0, 0, 0);
        row(9,  2'b00, 0, 0, 0, 1, 32'hBEEF_0008, 1, 8, 0, 0);
        row(10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        row(11, 2'b11, 32'hA000_0000, 32'hB000_0000, 0, 0, 0, 0, 0, 0, 0);
        row(12, 2'b11, 32'hA000_0001, 32'hB000_0001, 0, 1, 32'hA000_0000, 0, 11, 1, 1);
        row(13, 2'b11, 32'hA000_0002, 32'hB000_0002, 0, 1, 32'hB000_0000, 1, 11, 2, 1);
        row(14, 2'b11, 32'hA000_0003, 32'hB000_0003, 0, 1, 32'hA000_0001, 0, 12, 3, 1);
        row(15, 2'b11, 32'hA000_0004, 32'hB000_0004, 0, 1, 32'hB000_0002, 1, 13, 4, 1);
        row(16, 2'b00, 0, 0, 0, 1, 32'hA000_0003, 0, 14, 4, 1);
        row(17, 2'b00, 0, 0, 0, 1, 32'hB000_0004, 1, 15, 4, 1);
        row(18, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4, 1);
        row(19, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        // Table: single-source latency, fairness, sticky clear.
        do_reset();
        for (int i = 0; i < NV; i++) begin
            cycle(tbl[i].sv, tbl[i].d0, tbl[i].d1, tbl[i].rdy, tbl[i].clr, 1);
            ets = '0;
`ifdef TRACE_SCHEDULER_TIMESTAMP_EN
            ets = tbl[i].ets;
`endif
            check($sformatf("vec[%0d]", i), observed(),
                  {tbl[i].ev, tbl[i].edata, tbl[i].esrc, ets, tbl[i].edc, tbl[i].est});
        end

        // Backpressure: six pulses with the sink stalled.
        do_reset();
        for (int k = 0; k < 6; k++) cycle(2'b01, 32'hD000_0000 + k, 0, 0, 0, 1);
        check("bp_drop_count", 83'(drop_count), 83'd1);
        check("bp_sticky", 83'(drop_sticky), 83'd1);
        check("bp_head", 83'({out_valid, out_data}), 83'({1'b1, 32'hD000_0000}));
        cycle(2'b00, 0, 0, 0, 0, 1);
        cycle(2'b00, 0, 0, 0, 0, 1);
        check("bp_stable", 83'({out_valid, out_data}), 83'({1'b1, 32'hD000_0000}));
        for (int j = 1; j <= 5; j++) begin
            cycle(2'b00, 0, 0, 1, 0, 1);
            if (j < 5) check($sformatf("bp_drain%0d", j), 83'(out_data), 83'(32'hD000_0000 + j));
            else check("bp_drained", 83'(out_valid), 83'd0);
        end

        // Same-cycle grant and refill.
        do_reset();
        cycle(2'b01, 32'h5555_0001, 0, 1, 0, 1);
        cycle(2'b01, 32'h5555_0002, 0, 1, 0, 1);
        check("refill_first", 83'({out_valid, out_data, drop_count}),
              83'({1'b1, 32'h5555_0001, 16'd0}));
        cycle(2'b00, 0, 0, 1, 0, 1);
        check("refill_next", 83'({out_valid, out_data, out_source, drop_count}),
              83'({1'b1, 32'h5555_0002, 1'b0, 16'd0}));

        // Mid-stream reset with three records buffered.
        do_reset();
        cycle(2'b11, 32'h1, 32'h2, 0, 0, 1);
        cycle(2'b11, 32'h3, 32'h4, 0, 0, 1);
        cycle(2'b11, 32'h5, 32'h6, 0, 0, 1);
        cycle(2'b00, 0, 0, 0, 0, 1);
        rst = 1'b0;
        #1;
        check("midrst_now", observed(), '0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) cycle(2'b00, 0, 0, 1, 0, 1);
        check("midrst_after", 83'({out_valid, drop_count}), 83'd0);

        // Randomized run against the model.
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            rsv  = 2'($urandom_range(0, 3));
            rrdy = ($urandom_range(0, 9) < 7);
            rclr = ($urandom_range(0, 49) == 0);
            cycle(rsv, $urandom, $urandom, rrdy, rclr, 1);
        end

        // Saturation: sink stalled, both sources pulse every cycle.
        do_reset();
        for (int k = 0; k < 32800; k++) cycle(2'b11, $urandom, $urandom, 0, 0, 0);
        check("sat_count", 83'(drop_count), 83'(16'hFFFF));
        check("sat_model", observed(), model_out());
        cycle(2'b01, 32'h77, 0, 0, 1, 1);
        check("clr_plus_drop", 83'({drop_count, drop_sticky}), 83'({16'd1, 1'b1}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_scheduler.md
TRACE_SCHEDULER -- requirements
Module: trace_scheduler

Interface
REQ-001 Parameter NUM_SOURCES, default 2: number of trace producers; legal range 2..8.
REQ-002 Parameter FIFO_DEPTH, default 4: output FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low (asserted at 0).
REQ-005 src_valid  input  NUM_SOURCES  one-cycle pulse per producer; a new trace record is present.
REQ-006 src_data  input  NUM_SOURCES x trace_output  record per producer, sampled when its src_valid=1.
REQ-007 out_valid  output  1  out_data holds a record.
REQ-008 out_ready  input  1  sink accepts; a transfer occurs when out_valid and out_ready are both 1.
REQ-009 out_data  output  trace_output  head-of-FIFO record.
REQ-010 out_source  output  clog2(NUM_SOURCES)  index of the producer of out_data.
REQ-011 out_timestamp  output  32  capture cycle of out_data (see Configuration).
REQ-012 drop_clr  input  1  synchronous clear of the drop counter.
REQ-013 drop_count  output  16  saturating count of dropped records.
REQ-014 drop_sticky  output  1  set on first drop; cleared only by drop_clr or reset.

Function
REQ-015 Each source has one holding register plus a full flag; src_valid=1 loads it at that edge, visible the next cycle.
REQ-016 Producers never see backpressure; src_valid=1 while the holding register is full and not being granted that cycle drops the new record, keeps the old one, and increments drop_count.
REQ-017 A holding register granted in the same cycle that its src_valid=1 accepts the new record; no drop.
REQ-018 Drops from several sources in one cycle add their count to drop_count, saturating at 16'hFFFF.
REQ-019 drop_clr=1 zeroes drop_count and drop_sticky; drops in the same cycle are counted after the clear (for example, clear plus one drop gives 1).
REQ-020 Arbiter: round-robin, at most one grant per cycle, among full holding registers, starting search at priority pointer p.
REQ-021 After a grant to source i, p becomes (i+1) mod NUM_SOURCES; with no grant, p is unchanged.
REQ-022 A grant happens only when the FIFO is not full, or is full with a pop in the same cycle.
REQ-023 A grant writes {data, source index, timestamp} into the FIFO and clears that holding register at the same edge.
REQ-024 out_valid = FIFO non-empty; out_data, out_source and out_timestamp come from the head entry and stay stable while out_valid=1 and out_ready=0.
REQ-025 Minimum latency: src_valid at cycle t, then grant in cycle t+1, then out_valid in cycle t+2.
REQ-026 Push and pop in the same cycle leave the occupancy unchanged; pop while empty and push while full without a pop cannot occur.
REQ-027 FIFO pointers wrap modulo FIFO_DEPTH; occupancy is tracked with a counter of clog2(FIFO_DEPTH)+1 bits.

Reset
REQ-028 While rst=0: all holding flags, FIFO pointers, occupancy, p, drop_count, drop_sticky and the timestamp counter are 0; out_valid=0, out_data=0, out_source=0, out_timestamp=0.
REQ-029 Reset asserted mid-operation discards all pending and buffered records immediately, without counting drops.
REQ-030 The first capture is allowed on the first rising edge after rst deasserts.

Configuration
REQ-031 Macro TRACE_SCHEDULER_TIMESTAMP_EN defined: a free-running 32-bit cycle counter (wrapping, 0 after reset) is latched into each holding register on capture and carried through the FIFO to out_timestamp.
REQ-032 Macro undefined: no counter and no timestamp storage exist; out_timestamp is constant 0 and the port list is unchanged.

Structure
REQ-033 Package ryuki_datatypes holds trace_output (existing) plus a new packed struct trace_sched_entry {trace_output data; source index; 32-bit timestamp} and the constant TRACE_DROP_COUNT_WIDTH=16.
REQ-034 The FIFO is a sub-module trace_fifo, parameterised by depth and entry type, with push/pop/full/empty; the arbiter and holding registers stay in trace_scheduler.

Verification
REQ-035 Single source: after reset, src_valid[0] pulse with data A at cycle 5 gives out_valid=1 at cycle 7 with out_data=A, out_source=0; with the macro defined, out_timestamp=5.
REQ-036 Fairness: both sources pulse every cycle with out_ready=1 and p=0, so grants alternate 0,1,0,1 and out_source alternates the same way.
REQ-037 Backpressure: out_ready=0, NUM_SOURCES=2, FIFO_DEPTH=4, six pulses on source 0, so the FIFO holds 4, the holding register holds 1, and drop_count=1 with drop_sticky=1.
REQ-038 Same-cycle grant and refill: source 0 full and granted while src_valid[0]=1, so there is no drop and the next record is output next.
REQ-039 Saturation and clear: force 65,537 drops, so drop_count=16'hFFFF; drop_clr together with one drop gives drop_count=1.
REQ-040 Mid-stream reset: rst=0 with 3 records buffered gives out_valid=0 and drop_count=0 immediately, with no stale output after release.
